// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches to imem and buffers {instr, pc} for decode.
// Latency: a response accepted in cycle t is presented on instr_valid in cycle t+1.
// Backpressure: requests are credit-limited so in-flight plus buffered never exceeds two.

module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic                         vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap naturally, so DEPTH must be a power of two.
    assign do_pop   = pop && (cnt != '0);
    assign do_push  = push && (cnt != CW'(DEPTH));
    assign vld      = (cnt != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  discard;
    logic [1:0]  occ;
    logic        pc_vld;
    logic [31:0] rsp_pc;
    logic        req_fire;
    logic        rsp_fire;
    logic        rsp_keep;
    logic        pop;
    logic        head_vld;
    fetch_ent_t  head;
    fetch_ent_t  push_ent;

    assign imem_req  = rst_n && !redirect && (({1'b0, outstanding} + {1'b0, occ}) < 3'd2);
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;
    assign rsp_fire  = imem_rvalid && pc_vld;
    assign rsp_keep  = rsp_fire && (discard == 2'd0);
    assign pop       = head_vld && instr_ready;
    assign push_ent  = '{instr: imem_rdata, pc: rsp_pc};

    // Request addresses queue in issue order; its occupancy is the outstanding count.
    // It is never flushed: responses squashed by a redirect still retire their slot.
    sync_fifo #(.W(32), .DEPTH(2)) u_pc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (req_fire),
        .push_dat (fetch_pc),
        .pop      (rsp_fire),
        .vld      (pc_vld),
        .head_dat (rsp_pc),
        .cnt      (outstanding)
    );

    sync_fifo #(.W($bits(fetch_ent_t)), .DEPTH(2)) u_instr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (rsp_keep),
        .push_dat (push_ent),
        .pop      (pop),
        .vld      (head_vld),
        .head_dat (head),
        .cnt      (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            discard  <= 2'd0;
        end else begin
            if (redirect)      fetch_pc <= redirect_pc & ~32'd3;
            else if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            // Everything still in flight at a redirect belongs to the old path.
            if (redirect)                          discard <= outstanding - 2'(rsp_fire);
            else if (rsp_fire && discard != 2'd0)  discard <= discard - 2'd1;
        end
    end

    assign instr_valid = head_vld;
    assign instr       = head_vld ? head.instr : 32'd0;
    assign instr_pc    = head_vld ? head.pc    : 32'd0;
    assign pc_plus8    = instr_pc + 32'd8;
    assign cond        = instr[31:28];
    assign op          = instr[27:26];
    assign funct       = instr[25:20];
    assign rd          = instr[15:12];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order queued memory model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] pend_q[$];
    bit          mem_hold = 1'b0;
    logic [31:0] exp_issue;
    logic [31:0] exp_pop;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8),
        .cond(cond), .op(op), .funct(funct), .rd(rd),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return a ^ 32'hE3A0_0000;
    endfunction

    // One clock: capture the handshake, cross the edge, then drive next response.
    task automatic cycle();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem_req && imem_gnt;
        a  = imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (hs && rst_n) pend_q.push_back(a);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        if (!mem_hold && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = fmem(pend_q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %h want 0", imem_req); else passed++;
        checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else passed++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %h want 0", instr_valid); else passed++;
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) $display("FAIL rst_instr: got %h/%h want 0/0", instr, instr_pc); else passed++;
        checks++; if (pc_plus8 !== 32'h8) $display("FAIL rst_pc8: got %h want 8", pc_plus8); else passed++;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        cycle();
        checks++; if (instr_valid !== 1'b0) $display("FAIL rst_spurious: got %h want 0", instr_valid); else passed++;
        imem_gnt = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rel_req: got %h @%h want 1 @0", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_stream();
        int npop = 0;
        cycle();
        checks++; if (instr_valid !== 1'b0) $display("FAIL strm_lat0: got %h want 0", instr_valid); else passed++;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL strm_req1: got %h @%h want 1 @4", imem_req, imem_addr); else passed++;
        cycle();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL strm_first: got %h pc %h want 1 pc 0", instr_valid, instr_pc); else passed++;
        checks++; if (instr !== 32'hE3A0_0000 || pc_plus8 !== 32'h8) $display("FAIL strm_word: got %h pc8 %h want e3a00000 pc8 8", instr, pc_plus8); else passed++;
        checks++; if (cond !== 4'hE || op !== 2'd0 || funct !== 6'h3A || rd !== 4'h0) $display("FAIL strm_fields: got %h %h %h %h want e 0 3a 0", cond, op, funct, rd); else passed++;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) $display("FAIL strm_credit: got %h @%h want 0 @8", imem_req, imem_addr); else passed++;
        exp_issue = 32'h8; exp_pop = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_gnt) begin
                checks++; if (imem_addr !== exp_issue) $display("FAIL strm_issue: got %h want %h", imem_addr, exp_issue); else passed++;
                exp_issue += 32'd4;
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pop || instr !== fmem(exp_pop) || pc_plus8 !== exp_pop + 32'd8)
                    $display("FAIL strm_pop: got pc %h instr %h pc8 %h want pc %h", instr_pc, instr, pc_plus8, exp_pop);
                else passed++;
                exp_pop += 32'd4; npop++;
            end
            cycle();
        end
        checks++; if (npop < 4) $display("FAIL strm_count: got %0d pops want >= 4", npop); else passed++;
    endtask

    task automatic test_backpressure();
        int npop = 0;
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req && imem_gnt) begin
                checks++; if (imem_addr !== exp_issue) $display("FAIL bp_issue: got %h want %h", imem_addr, exp_issue); else passed++;
                exp_issue += 32'd4;
            end
            cycle();
        end
        checks++; if (imem_req !== 1'b0) $display("FAIL bp_full_req: got %h want 0", imem_req); else passed++;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pop) $display("FAIL bp_head: got %h pc %h want 1 pc %h", instr_valid, instr_pc, exp_pop); else passed++;
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_gnt) begin
                checks++; if (imem_addr !== exp_issue) $display("FAIL bp_issue2: got %h want %h", imem_addr, exp_issue); else passed++;
                exp_issue += 32'd4;
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pop || instr !== fmem(exp_pop))
                    $display("FAIL bp_pop: got pc %h instr %h want pc %h", instr_pc, instr, exp_pop);
                else passed++;
                exp_pop += 32'd4; npop++;
            end
            cycle();
        end
        checks++; if (npop < 5) $display("FAIL bp_count: got %0d pops want >= 5", npop); else passed++;
    endtask

    task automatic test_gnt_stall();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid && instr_ready) begin
                checks++; if (instr_pc !== exp_pop) $display("FAIL stall_pop: got %h want %h", instr_pc, exp_pop); else passed++;
                exp_pop += 32'd4;
            end
            cycle();
            checks++; if (imem_addr !== exp_issue) $display("FAIL stall_addr: got %h want %h", imem_addr, exp_issue); else passed++;
        end
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) $display("FAIL stall_req: got req %h valid %h want 1 0", imem_req, instr_valid); else passed++;
        imem_gnt = 1'b1;
    endtask

    task automatic test_redirect();
        rst_n = 1'b0; pend_q.delete(); imem_rvalid = 1'b0;
        cycle();
        mem_hold = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
        cycle();
        cycle();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) $display("FAIL rd_two_out: got %h @%h want 0 @8", imem_req, imem_addr); else passed++;
        mem_hold = 1'b0;
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL rd_req_blk: got %h want 0", imem_req); else passed++;
        cycle();
        redirect = 1'b0; #1;
        checks++; if (instr_valid !== 1'b0) $display("FAIL rd_flush: got %h want 0", instr_valid); else passed++;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rd_target: got %h @%h want 1 @100", imem_req, imem_addr); else passed++;
        cycle();
        checks++; if (instr_valid !== 1'b0) $display("FAIL rd_drop2: got %h want 0", instr_valid); else passed++;
        checks++; if (imem_addr !== 32'h104) $display("FAIL rd_next: got %h want 104", imem_addr); else passed++;
        cycle();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) $display("FAIL rd_first: got %h pc %h want 1 pc 100", instr_valid, instr_pc); else passed++;
        checks++; if (instr !== 32'hE3A0_0100 || pc_plus8 !== 32'h108) $display("FAIL rd_word: got %h pc8 %h want e3a00100 108", instr, pc_plus8); else passed++;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL wr_req_blk: got %h want 0", imem_req); else passed++;
        cycle();
        redirect = 1'b0; #1;
        checks++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || pc_plus8 !== 32'h8) $display("FAIL wr_pop_flush: got %h pc %h pc8 %h want 0 0 8", instr_valid, instr_pc, pc_plus8); else passed++;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_target: got %h @%h want 1 @fffffffc", imem_req, imem_addr); else passed++;
        cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wr_wrap: got %h @%h want 1 @0", imem_req, imem_addr); else passed++;
        cycle();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) $display("FAIL wr_head: got %h pc %h want 1 fffffffc", instr_valid, instr_pc); else passed++;
        checks++; if (instr !== 32'h1C5F_FFFC || pc_plus8 !== 32'h4) $display("FAIL wr_word: got %h pc8 %h want 1c5ffffc 4", instr, pc_plus8); else passed++;
        checks++; if (cond !== 4'h1 || op !== 2'd3 || funct !== 6'h05 || rd !== 4'hF) $display("FAIL wr_fields: got %h %h %h %h want 1 3 05 f", cond, op, funct, rd); else passed++;
    endtask

    task automatic test_reset_midflight();
        instr_ready = 1'b0;
        cycle();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) $display("FAIL mf_full: got %h %h pc %h want 0 1 fffffffc", imem_req, instr_valid, instr_pc); else passed++;
        rst_n = 1'b0; pend_q.delete(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL mf_rst_ctl: got %h %h want 0 0", imem_req, instr_valid); else passed++;
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || pc_plus8 !== 32'h8 || imem_addr !== 32'h0) $display("FAIL mf_rst_dat: got %h %h %h %h want 0 0 8 0", instr, instr_pc, pc_plus8, imem_addr); else passed++;
        cycle();
        instr_ready = 1'b1; rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL mf_restart: got %h @%h v %h want 1 @0 v 0", imem_req, imem_addr, instr_valid); else passed++;
        cycle();
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h4) $display("FAIL mf_stale: got v %h @%h want 0 @4", instr_valid, imem_addr); else passed++;
        cycle();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hE3A0_0000) $display("FAIL mf_first: got %h pc %h %h want 1 0 e3a00000", instr_valid, instr_pc, instr); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
